dc_exp_unit: RTL and testbench

- Parametrised, registered successor to the combinational dcache exception checker.
- Checks NUM_CH memory-access channels per cycle against segment limits and a TLB_ENTRIES-entry fully associative TLB view.
- Prioritises the result, then captures one exception (type, channel, faulting linear address, x86-style error code) in a holding register until the exception handler acknowledges it.
- Sits between read-operands and the dcache; back-pressures the read-operands stage while an exception is pending.

---
 rtl/dc_exp_unit.sv | 140 ++++++++++++++
 tb/tb_dc_exp_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dc_exp_unit.sv
// dc_exp_unit: registered dcache exception checker with one-deep exception hold
// Ports: clk/rst_n (async active-low); in_valid/in_ready bundle handshake;
//   isr suppresses detection; ch_* per-channel access, limits and addresses;
//   tlb_* fully associative TLB view; exp_* held exception and exp_ack;
//   exp_count saturating fault counter, built only with DC_EXP_CNT_EN defined.
module dc_exp_unit #(
    parameter int NUM_CH      = 2,
    parameter int TLB_ENTRIES = 8,
    parameter int VPN_W       = 20,
    localparam int AW = VPN_W + 12,
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       isr,
    input  logic [NUM_CH-1:0]          ch_en,
    input  logic [NUM_CH-1:0]          ch_wr,
    input  logic [NUM_CH*AW-1:0]       ch_addr,
    input  logic [NUM_CH*AW-1:0]       ch_addr_end,
    input  logic [NUM_CH*32-1:0]       ch_off_end,
    input  logic [NUM_CH*32-1:0]       ch_seg_lim,
    input  logic [TLB_ENTRIES*VPN_W-1:0] tlb_vpn,
    input  logic [TLB_ENTRIES-1:0]     tlb_valid,
    input  logic [TLB_ENTRIES-1:0]     tlb_pr,
    input  logic [TLB_ENTRIES-1:0]     tlb_rw,
    output logic                       exp_valid,
    input  logic                       exp_ack,
    output logic                       exp_prot,
    output logic [CW-1:0]              exp_ch,
    output logic [AW-1:0]              exp_addr,
    output logic [2:0]                 exp_err,
    output logic [15:0]                exp_count
);
    typedef enum logic {IDLE, PEND} state_t;
    state_t state_q, state_d;
    logic prot_q, prot_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0] err_q, err_d;
    logic any_f, f_prot, lim, cap;
    logic [CW-1:0] f_ch;
    logic [AW-1:0] f_addr;
    logic [2:0] f_err;
    logic [1:0] s_chk, e_chk;

    // Returns {fault, denied}; scanning high to low lets the lowest matching entry win.
    function automatic logic [1:0] pg_chk(input logic [VPN_W-1:0] vpn, input logic wr);
        logic hit, pr, rw, denied;
        hit = 1'b0;
        pr = 1'b0;
        rw = 1'b0;
        for (int e = TLB_ENTRIES - 1; e >= 0; e--)
            if (tlb_valid[e] && tlb_vpn[e*VPN_W +: VPN_W] == vpn) begin
                hit = 1'b1;
                pr = tlb_pr[e];
                rw = tlb_rw[e];
            end
        denied = hit & pr & wr & ~rw;
        return {~hit | ~pr | denied, denied};
    endfunction

    // High-to-low scan so the lowest faulting channel is the final assignment.
    always_comb begin
        any_f = 1'b0;
        f_prot = 1'b0;
        f_ch = '0;
        f_addr = '0;
        f_err = '0;
        s_chk = '0;
        e_chk = '0;
        lim = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            s_chk = pg_chk(ch_addr[i*AW+12 +: VPN_W], ch_wr[i]);
            e_chk = pg_chk(ch_addr_end[i*AW+12 +: VPN_W], ch_wr[i]);
            lim = ch_off_end[i*32 +: 32] > ch_seg_lim[i*32 +: 32];
            if (ch_en[i] && (lim || s_chk[1] || e_chk[1])) begin
                any_f = 1'b1;
                f_prot = lim;
                f_ch = CW'(i);
                f_addr = lim ? '0 : s_chk[1] ? ch_addr[i*AW +: AW] : ch_addr_end[i*AW +: AW];
                f_err = lim ? 3'b000 : {1'b0, ch_wr[i], s_chk[1] ? s_chk[0] : e_chk[0]};
            end
        end
    end

    always_comb begin
        cap = state_q == IDLE && in_valid && any_f && !isr;
        state_d = state_q;
        prot_d = prot_q;
        ch_d = ch_q;
        addr_d = addr_q;
        err_d = err_q;
        if (cap) begin
            state_d = PEND;
            prot_d = f_prot;
            ch_d = f_ch;
            addr_d = f_addr;
            err_d = f_err;
        end else if (state_q == PEND && exp_ack) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prot_q <= 1'b0;
            ch_q <= '0;
            addr_q <= '0;
            err_q <= '0;
        end else begin
            state_q <= state_d;
            prot_q <= prot_d;
            ch_q <= ch_d;
            addr_q <= addr_d;
            err_q <= err_d;
        end
    end

`ifdef DC_EXP_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    assign cnt_d = cnt_q + 16'(cap && cnt_q != 16'hFFFF);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign exp_count = cnt_q;
`else
    assign exp_count = 16'h0000;
`endif

    assign in_ready = state_q == IDLE;
    assign exp_valid = state_q == PEND;
    assign exp_prot = prot_q;
    assign exp_ch = ch_q;
    assign exp_addr = addr_q;
    assign exp_err = err_q;
endmodule

// File: tb/tb_dc_exp_unit.sv
// tb_dc_exp_unit: directed self-checking bench for dc_exp_unit
module tb_dc_exp_unit;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, isr = 1'b0, exp_ack = 1'b0;
    logic in_ready, exp_valid, exp_prot;
    logic [1:0] ch_en = '0, ch_wr = '0;
    logic [63:0] ch_addr = '0, ch_addr_end = '0, ch_off_end = '0, ch_seg_lim = '0;
    logic [159:0] tlb_vpn = '0;
    logic [7:0] tlb_valid = '0, tlb_pr = '0, tlb_rw = '0;
    logic [0:0] exp_ch;
    logic [31:0] exp_addr;
    logic [2:0] exp_err;
    logic [15:0] exp_count;
    int vectors = 0, miscompares = 0;

    dc_exp_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .isr(isr),
        .ch_en(ch_en), .ch_wr(ch_wr), .ch_addr(ch_addr), .ch_addr_end(ch_addr_end),
        .ch_off_end(ch_off_end), .ch_seg_lim(ch_seg_lim), .tlb_vpn(tlb_vpn),
        .tlb_valid(tlb_valid), .tlb_pr(tlb_pr), .tlb_rw(tlb_rw), .exp_valid(exp_valid),
        .exp_ack(exp_ack), .exp_prot(exp_prot), .exp_ch(exp_ch), .exp_addr(exp_addr),
        .exp_err(exp_err), .exp_count(exp_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tlb(input int e, input logic [19:0] vpn, input logic v, input logic pr, input logic rw);
        tlb_vpn[e*20 +: 20] = vpn;
        tlb_valid[e] = v;
        tlb_pr[e] = pr;
        tlb_rw[e] = rw;
    endtask

    task automatic set_ch(input int i, input logic en, input logic wr, input logic [31:0] a,
                          input logic [31:0] ae, input logic [31:0] off, input logic [31:0] lim);
        ch_en[i] = en;
        ch_wr[i] = wr;
        ch_addr[i*32 +: 32] = a;
        ch_addr_end[i*32 +: 32] = ae;
        ch_off_end[i*32 +: 32] = off;
        ch_seg_lim[i*32 +: 32] = lim;
    endtask

    task automatic accept();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic ack();
        exp_ack = 1'b1;
        step();
        exp_ack = 1'b0;
    endtask

    initial begin
        set_tlb(0, 20'h00010, 1, 1, 1);
        set_tlb(1, 20'h00001, 1, 1, 1);
        set_tlb(2, 20'h00020, 1, 0, 1);
        set_tlb(5, 20'h00403, 1, 1, 0);
        set_tlb(6, 20'h00403, 1, 1, 1);
        #12;
        chk("reset_valid", 32'(exp_valid), 0);
        chk("reset_addr", exp_addr, 0);
        chk("reset_err", 32'(exp_err), 0);
        rst_n = 1'b1;
        step();
        chk("reset_ready", 32'(in_ready), 1);
        chk("reset_count", 32'(exp_count), 0);
        // limit fault on ch0 read with a TLB hit
        set_ch(0, 1, 0, 32'h0001_0000, 32'h0001_0003, 32'h1000, 32'h0FFF);
        in_valid = 1'b1;
        chk("lim_pre_valid", 32'(exp_valid), 0);
        step();
        in_valid = 1'b0;
        chk("lim_valid", 32'(exp_valid), 1);
        chk("lim_prot", 32'(exp_prot), 1);
        chk("lim_ch", 32'(exp_ch), 0);
        chk("lim_err", 32'(exp_err), 0);
        chk("lim_addr", exp_addr, 0);
        chk("lim_ready", 32'(in_ready), 0);
        in_valid = 1'b1;
        set_ch(0, 1, 0, 32'h0000_1FFE, 32'h0000_2001, 32'h10, 32'hFFFF);
        step();
        in_valid = 1'b0;
        chk("pend_hold_valid", 32'(exp_valid), 1);
        chk("pend_hold_prot", 32'(exp_prot), 1);
        ack();
        chk("ack_valid", 32'(exp_valid), 0);
        chk("ack_ready", 32'(in_ready), 1);
        // ack in IDLE is ignored
        ack();
        chk("idle_ack_ready", 32'(in_ready), 1);
        // clean read within limits and mapped: no fault
        set_ch(0, 1, 0, 32'h0001_0000, 32'h0001_0003, 32'h0FFF, 32'h0FFF);
        accept();
        chk("clean_valid", 32'(exp_valid), 0);
        // read of a read-only page is allowed
        set_ch(0, 0, 0, 0, 0, 0, 0);
        set_ch(1, 1, 0, 32'h0040_3010, 32'h0040_3013, 32'h10, 32'hFFFF);
        accept();
        chk("ro_read_valid", 32'(exp_valid), 0);
        // write to read-only page; entry 5 beats duplicate writable entry 6
        set_ch(1, 1, 1, 32'h0040_3010, 32'h0040_3013, 32'h10, 32'hFFFF);
        accept();
        chk("ro_wr_valid", 32'(exp_valid), 1);
        chk("ro_wr_prot", 32'(exp_prot), 0);
        chk("ro_wr_ch", 32'(exp_ch), 1);
        chk("ro_wr_addr", exp_addr, 32'h0040_3010);
        chk("ro_wr_err", 32'(exp_err), 3'b011);
        ack();
        // page-crossing read, end page missing
        set_ch(1, 0, 0, 0, 0, 0, 0);
        set_ch(0, 1, 0, 32'h0000_1FFE, 32'h0000_2001, 32'h10, 32'hFFFF);
        accept();
        chk("cross_prot", 32'(exp_prot), 0);
        chk("cross_ch", 32'(exp_ch), 0);
        chk("cross_addr", exp_addr, 32'h0000_2001);
        chk("cross_err", 32'(exp_err), 3'b000);
        ack();
        // write to a not-present page
        set_ch(0, 1, 1, 32'h0002_0004, 32'h0002_0007, 32'h10, 32'hFFFF);
        accept();
        chk("np_addr", exp_addr, 32'h0002_0004);
        chk("np_err", 32'(exp_err), 3'b010);
        ack();
        // both channels faulting: ch0 wins
        set_ch(0, 1, 0, 32'h0000_1FFE, 32'h0000_2001, 32'h10, 32'hFFFF);
        set_ch(1, 1, 1, 32'h0040_3010, 32'h0040_3013, 32'h10, 32'hFFFF);
        accept();
        chk("prio_ch", 32'(exp_ch), 0);
        chk("prio_addr", exp_addr, 32'h0000_2001);
        ack();
        // same bundle with isr suppressed
        isr = 1'b1;
        accept();
        isr = 1'b0;
        chk("isr_valid", 32'(exp_valid), 0);
        chk("isr_ready", 32'(in_ready), 1);
        // faulting data but in_valid low / all channels disabled
        step();
        chk("noval_valid", 32'(exp_valid), 0);
        ch_en = '0;
        accept();
        chk("noen_valid", 32'(exp_valid), 0);
        // reset while pending
        ch_en = 2'b11;
        accept();
        chk("rst_pre_valid", 32'(exp_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(exp_valid), 0);
        chk("rst_async_ch", 32'(exp_ch), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_count", 32'(exp_count), 0);
        for (int k = 0; k < 3; k++) begin
            accept();
            ack();
        end
`ifdef DC_EXP_CNT_EN
        chk("count_3", 32'(exp_count), 3);
        force dut.cnt_q = 16'hFFFF;
        step();
        release dut.cnt_q;
        accept();
        ack();
        chk("count_sat", 32'(exp_count), 32'hFFFF);
`else
        chk("count_tied", 32'(exp_count), 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
